// File: rtl/mmu_mem_pkg.sv
// mmu_mem_pkg: shared types for the MMU line-memory request path.
// Engine state encoding, default widths and the request entry layout.
package mmu_mem_pkg;

    localparam int MMU_DATA_W    = 512;
    localparam int MMU_MASK_W    = 64;
    localparam int MMU_ADDR_W    = 34;
    localparam int MMU_REQ_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                  wr;
        logic [MMU_ADDR_W-1:0] addr;
        logic [MMU_DATA_W-1:0] data;
        logic [MMU_MASK_W-1:0] mask;
    } mem_req_t;

    // Flat entry width for any widths; field order matches mem_req_t.
    function automatic int req_entry_w(int aw, int dw, int mw);
        return 1 + aw + dw + mw;
    endfunction

endpackage

// File: rtl/mem_master_if.sv
// mem_master_if: request, response and memory pin bundle of mem_master.
// 'master' is the engine's view; 'slave' is the clients-plus-memory side.
interface mem_master_if
    import mmu_mem_pkg::*;
#(
    parameter int DATA_WIDTH = MMU_DATA_W,
    parameter int MASK_WIDTH = MMU_MASK_W,
    parameter int ADDR_WIDTH = MMU_ADDR_W
) ();

    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_wr;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_req_data;
    logic [MASK_WIDTH-1:0] i_req_mask;

    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic                  o_rsp_wr;
    logic [DATA_WIDTH-1:0] o_rsp_data;

    logic                  o_mem_cs;
    logic                  o_mem_wren;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_din;
    logic [MASK_WIDTH-1:0] o_mem_byte_mask;
    logic [DATA_WIDTH-1:0] i_mem_dout;

    modport master (
        input  i_req_valid,
        input  i_req_wr,
        input  i_req_addr,
        input  i_req_data,
        input  i_req_mask,
        input  i_rsp_ready,
        input  i_mem_dout,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_wr,
        output o_rsp_data,
        output o_mem_cs,
        output o_mem_wren,
        output o_mem_addr,
        output o_mem_din,
        output o_mem_byte_mask
    );

    modport slave (
        output i_req_valid,
        output i_req_wr,
        output i_req_addr,
        output i_req_data,
        output i_req_mask,
        output i_rsp_ready,
        output i_mem_dout,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_wr,
        input  o_rsp_data,
        input  o_mem_cs,
        input  o_mem_wren,
        input  o_mem_addr,
        input  o_mem_din,
        input  o_mem_byte_mask
    );

endinterface

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: small synchronous FIFO used by the MMU request queues.
// Head is read combinationally; push when full and pop when empty are ignored.
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/mem_master.sv
// mem_master: in-order request engine and sole driver of the line memory.
// Queues client requests, issues one access at a time, returns one response each.
module mem_master
    import mmu_mem_pkg::*;
#(
    parameter int DATA_WIDTH = MMU_DATA_W,
    parameter int MASK_WIDTH = MMU_MASK_W,
    parameter int ADDR_WIDTH = MMU_ADDR_W,
    parameter int REQ_DEPTH  = MMU_REQ_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    mem_master_if.master bus
);

    localparam int ENTRY_W = req_entry_w(ADDR_WIDTH, DATA_WIDTH, MASK_WIDTH);
    localparam int CNT_W   = $clog2(REQ_DEPTH + 1);

    mem_state_t r_state;
    mem_state_t w_next;

    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [ENTRY_W-1:0]    w_entry_in;
    logic [ENTRY_W-1:0]    w_head;

    logic                  w_head_wr;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [MASK_WIDTH-1:0] w_head_mask;

    logic                  w_issue;
    logic                  w_capture;
    logic                  w_rsp_hs;

    logic                  r_rsp_wr;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    assign w_push     = bus.i_req_valid & ~w_full;
    assign w_entry_in = {bus.i_req_wr, bus.i_req_addr,
                         bus.i_req_data, bus.i_req_mask};

    mem_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_entry_in),
        .i_pop   (w_issue),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign {w_head_wr, w_head_addr, w_head_data, w_head_mask} = w_head;

    assign w_rsp_hs = (r_state == ST_RESP) & bus.i_rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and issue decision; RESP may hand off and issue in one cycle.
    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_issue = ~w_empty;
            end
            ST_RD_WAIT: begin
                w_capture = 1'b1;
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                if (bus.i_rsp_ready) begin
                    if (w_empty) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_issue = 1'b1;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (w_issue) begin
            w_next = w_head_wr ? ST_RESP : ST_RD_WAIT;
        end
    end

    // Response register: read data, write ack, or cleared once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_wr   <= 1'b0;
            r_rsp_data <= '0;
        end else if (w_capture) begin
            r_rsp_wr   <= 1'b0;
            r_rsp_data <= bus.i_mem_dout;
        end else if (w_issue && w_head_wr) begin
            r_rsp_wr   <= 1'b1;
            r_rsp_data <= '0;
        end else if (w_rsp_hs) begin
            r_rsp_wr   <= 1'b0;
            r_rsp_data <= '0;
        end
    end

    // Memory pins are quiet unless an access issues this cycle.
    assign bus.o_mem_cs        = w_issue;
    assign bus.o_mem_wren      = w_issue & w_head_wr;
    assign bus.o_mem_addr      = w_issue ? w_head_addr : '0;
    assign bus.o_mem_din       = w_issue ? w_head_data : '0;
    assign bus.o_mem_byte_mask = (w_issue & w_head_wr) ? w_head_mask : '0;

    assign bus.o_req_ready = (w_count != CNT_W'(REQ_DEPTH));
    assign bus.o_rsp_valid = (r_state == ST_RESP);
    assign bus.o_rsp_wr    = r_rsp_wr;
    assign bus.o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: scoreboard bench for mem_master with a line-memory model.
// Expected responses and issues are queued at acceptance; monitors compare.
module tb_mem_master;
    import mmu_mem_pkg::*;

    localparam int DW = MMU_DATA_W;
    localparam int MW = MMU_MASK_W;
    localparam int AW = MMU_ADDR_W;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_master_if bus ();

    mem_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] chip [64];
    logic [DW-1:0] refm [64];
    bit            loaded = 1'b0;

    rsp_t     exp_rsp [$];
    mem_req_t exp_iss [$];

    bit rdy_rand  = 1'b0;
    bit rdy_force = 1'b1;
    int cs_run    = 0;
    int cs_max    = 0;

    function automatic logic [DW-1:0] init_line(input int i);
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) begin
            r[k*32 +: 32] = 32'h9E37_79B9 * 32'(i + 1) + 32'(k);
        end
        if (i == 16) r = {64{8'hA5}};
        if (i == 32) r = {64{8'h3C}};
        return r;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) begin
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", nm, what);
    endtask

    // Line memory: one-cycle registered read, byte-masked write.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) chip[i] = init_line(i);
            loaded = 1'b1;
        end
        if (rst) begin
            bus.i_mem_dout <= '0;
        end else if (bus.o_mem_cs) begin
            if (bus.o_mem_wren) begin
                chip[bus.o_mem_addr[11:6]] = merge(chip[bus.o_mem_addr[11:6]],
                                                   bus.o_mem_din,
                                                   bus.o_mem_byte_mask);
            end else begin
                bus.i_mem_dout <= chip[bus.o_mem_addr[11:6]];
            end
        end
    end

    initial begin
        bus.i_rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: pin gating, issue order/content, response content.
    always @(negedge clk) begin
        mem_req_t e;
        if (!rst) begin
            if (!bus.o_mem_wren) chk("mask_gate", DW'(bus.o_mem_byte_mask), '0);
            if (!bus.o_mem_cs) chk("din_gate", bus.o_mem_din, '0);
            if (bus.o_mem_cs) begin
                cs_run++;
                if (cs_run > cs_max) cs_max = cs_run;
                if (exp_iss.size() == 0) begin
                    fail_evt("issue", "o_mem_cs with no pending request");
                end else begin
                    e = exp_iss.pop_front();
                    chk("iss_wren", DW'(bus.o_mem_wren), DW'(e.wr));
                    chk("iss_addr", DW'(bus.o_mem_addr), DW'(e.addr));
                    if (e.wr) begin
                        chk("iss_din", bus.o_mem_din, e.data);
                        chk("iss_mask", DW'(bus.o_mem_byte_mask), DW'(e.mask));
                    end
                end
            end else begin
                cs_run = 0;
            end
            if (bus.o_rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    fail_evt("rsp", "o_rsp_valid with no pending request");
                end else begin
                    chk("rsp_wr", DW'(bus.o_rsp_wr), DW'(exp_rsp[0].wr));
                    chk("rsp_data", bus.o_rsp_data, exp_rsp[0].data);
                    if (bus.i_rsp_ready) void'(exp_rsp.pop_front());
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [MW-1:0] mask);
        int       k;
        int       idx;
        mem_req_t e;
        rsp_t     r;
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_wr    = wr;
        bus.i_req_addr  = addr;
        bus.i_req_data  = data;
        bus.i_req_mask  = mask;
        k = 0;
        while (!bus.o_req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.o_req_ready) begin
            fail_evt("req_accept", "o_req_ready stuck low");
            bus.i_req_valid = 1'b0;
        end else begin
            e.wr   = wr;
            e.addr = addr;
            e.data = data;
            e.mask = mask;
            exp_iss.push_back(e);
            idx = int'(addr[11:6]);
            if (wr) begin
                refm[idx] = merge(refm[idx], data, mask);
                r.wr   = 1'b1;
                r.data = '0;
            end else begin
                r.wr   = 1'b0;
                r.data = refm[idx];
            end
            exp_rsp.push_back(r);
            @(posedge clk);
            #1;
            bus.i_req_valid = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (exp_rsp.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (exp_rsp.size() != 0) begin
            n_bad++;
            $display("FAIL drain_%s: got %0d outstanding want 0", nm, exp_rsp.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] a5;
        logic [AW-1:0] ra;
        logic [63:0]   t;
        a5 = {64{8'hA5}};
        for (int i = 0; i < 64; i++) refm[i] = init_line(i);
        bus.i_req_valid = 1'b0;
        bus.i_req_wr    = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_data  = '0;
        bus.i_req_mask  = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", DW'(bus.o_req_ready), DW'(1));
        chk("rst_rsp_valid", DW'(bus.o_rsp_valid), '0);
        chk("rst_rsp_wr", DW'(bus.o_rsp_wr), '0);
        chk("rst_rsp_data", bus.o_rsp_data, '0);
        chk("rst_mem_cs", DW'(bus.o_mem_cs), '0);
        chk("rst_mem_wren", DW'(bus.o_mem_wren), '0);
        chk("rst_mem_addr", DW'(bus.o_mem_addr), '0);

        // Single read at 0x400: issue T+1, response T+3.
        send(1'b0, 34'h400, '0, '0);
        @(negedge clk);
        chk("rd_t1_cs", DW'(bus.o_mem_cs), DW'(1));
        chk("rd_t1_wren", DW'(bus.o_mem_wren), '0);
        @(negedge clk);
        chk("rd_t2_cs", DW'(bus.o_mem_cs), '0);
        chk("rd_t2_valid", DW'(bus.o_rsp_valid), '0);
        @(negedge clk);
        chk("rd_t3_valid", DW'(bus.o_rsp_valid), DW'(1));
        chk("rd_t3_data", bus.o_rsp_data, a5);
        drain("rd");

        // Masked write at 0x800 then read back.
        send(1'b1, 34'h800, {64{8'hFF}}, 64'h1);
        @(negedge clk);
        chk("wr_t1_cs", DW'(bus.o_mem_cs), DW'(1));
        chk("wr_t1_wren", DW'(bus.o_mem_wren), DW'(1));
        @(negedge clk);
        chk("wr_t2_valid", DW'(bus.o_rsp_valid), DW'(1));
        chk("wr_t2_wr", DW'(bus.o_rsp_wr), DW'(1));
        chk("wr_t2_data", bus.o_rsp_data, '0);
        send(1'b0, 34'h800, '0, '0);
        drain("wr_rd");

        // Backpressure: three reads with the consumer stalled.
        rdy_force = 1'b0;
        send(1'b0, 34'h040, '0, '0);
        send(1'b0, 34'h400, '0, '0);
        send(1'b0, 34'h800, '0, '0);
        @(negedge clk);
        chk("bp_req_ready", DW'(bus.o_req_ready), '0);
        repeat (3) @(negedge clk);
        chk("bp_req_ready_hold", DW'(bus.o_req_ready), '0);
        chk("bp_rsp_valid_hold", DW'(bus.o_rsp_valid), DW'(1));
        rdy_force = 1'b1;
        drain("bp");

        // Back-to-back writes: four consecutive issue cycles.
        cs_max = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, AW'(34'h100 + 34'(i * 64)), rand_line(), {$urandom(), $urandom()});
        end
        drain("b2b");
        chk("b2b_cs_run", DW'(cs_max), DW'(4));

        // Reset while the read waits for memory data.
        send(1'b0, 34'h400, '0, '0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_rsp.delete();
        exp_iss.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("mrst_rsp_valid", DW'(bus.o_rsp_valid), '0);
        chk("mrst_req_ready", DW'(bus.o_req_ready), DW'(1));
        chk("mrst_mem_cs", DW'(bus.o_mem_cs), '0);
        repeat (5) @(negedge clk);

        // Random traffic with random consumer stalls.
        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            t  = {$urandom(), $urandom()};
            ra = t[AW-1:0];
            ra[11:6] = 6'($urandom_range(14, 20));
            send(1'($urandom_range(0, 1)), ra, rand_line(), {$urandom(), $urandom()});
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        drain("rand");
        chk("iss_queue_empty", DW'(exp_iss.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
